c499_misr: RTL and testbench

Downstream response compactor for the c499 circuit under test. It samples the 32-bit c499 output word on every valid cycle and folds it into a 32-bit multiple-input signature register (MISR). After a programmed number of patterns it stops, holds the final signature and flags pass/fail against an expected value. It sits between the c499 instance and the bench or BIST checker, so a whole random-pattern run is judged by one 32-bit compare instead of per-vector checking.

---
 rtl/c499_bist_pkg.sv | 31 +++
 rtl/c499_misr_core.sv | 33 +++
 rtl/c499_misr.sv | 103 ++++++++++
 tb/tb_c499_misr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/c499_bist_pkg.sv
// Shared definitions for the c499 BIST slice: FSM states, MISR defaults
// and the single definition of the MISR fold step.
package c499_bist_pkg;

  localparam int C499_OUT_W = 32;

  localparam logic [C499_OUT_W-1:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [C499_OUT_W-1:0] DEFAULT_SEED = 32'h00000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } misr_state_t;

  // One MISR step: shift left, fold the dropped MSB back through the
  // polynomial (implicit x^32 term), then XOR in the new response word.
  function automatic logic [C499_OUT_W-1:0] misr_next(
    input logic [C499_OUT_W-1:0] sig,
    input logic [C499_OUT_W-1:0] data,
    input logic [C499_OUT_W-1:0] poly
  );
    logic [C499_OUT_W-1:0] shifted;
    shifted = {sig[C499_OUT_W-2:0], 1'b0};
    if (sig[C499_OUT_W-1]) begin
      shifted = shifted ^ poly;
    end
    return shifted ^ data;
  endfunction

endpackage

// File: rtl/c499_misr_core.sv
// Signature register of the c499 response compactor. Loads the seed on
// reset or on a run start, folds one response word per enabled cycle.
module c499_misr_core
  import c499_bist_pkg::*;
#(
  parameter logic [C499_OUT_W-1:0] POLY = DEFAULT_POLY,
  parameter logic [C499_OUT_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [C499_OUT_W-1:0] data,
  output logic [C499_OUT_W-1:0] sig,
  output logic [C499_OUT_W-1:0] sig_next
);

  // Value the register takes if this cycle's sample is accepted; the top
  // level compares it against the golden signature on the last sample.
  always_comb begin
    sig_next = misr_next(sig, data, POLY);
  end

  // Seed load has priority over folding; reset behaves like a seed load.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/c499_misr.sv
// c499 response compactor: FSM and pattern counter around the MISR core.
// Input handshake: resp_data is consumed on every rising edge where
// resp_valid is high while in RUN; there is no ready, the compactor never
// stalls the upstream source, and valid is ignored outside RUN.
module c499_misr
  import c499_bist_pkg::*;
#(
  parameter int               WIDTH        = C499_OUT_W,
  parameter int               NUM_PATTERNS = 1024,
  parameter int               CNT_W        = 16,
  parameter logic [WIDTH-1:0] POLY         = DEFAULT_POLY,
  parameter logic [WIDTH-1:0] SEED         = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [WIDTH-1:0]  resp_data,
  input  logic [WIDTH-1:0]  expected,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [WIDTH-1:0]  signature,
  output logic [CNT_W-1:0]  count,
  output misr_state_t       state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

  misr_state_t      state_q;
  misr_state_t      state_d;
  logic [CNT_W-1:0] count_q;
  logic             pass_q;
  logic [WIDTH-1:0] sig_next;
  logic             accept;
  logic             last_sample;
  logic             load_seed;

  // Start is honoured from IDLE and DONE only; a sample counts only in RUN.
  always_comb begin
    load_seed   = (state_q != ST_RUN) && start;
    accept      = (state_q == ST_RUN) && resp_valid;
    last_sample = accept && (count_q == LAST_IDX);
  end

  // Next-state logic for the IDLE -> RUN -> DONE run sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)       state_d = ST_RUN;
      ST_RUN:  if (last_sample) state_d = ST_DONE;
      ST_DONE: if (start)       state_d = ST_RUN;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pattern counter: cleared on run start, stops at NUM_PATTERNS.
  always_ff @(posedge clk) begin
    if (rst || load_seed) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Verdict captured on the last sample against the post-update signature.
  always_ff @(posedge clk) begin
    if (rst || load_seed) begin
      pass_q <= 1'b0;
    end else if (last_sample) begin
      pass_q <= (sig_next == expected);
    end
  end

  c499_misr_core #(
    .POLY (POLY),
    .SEED (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load_seed),
    .en       (accept),
    .data     (resp_data),
    .sig      (signature),
    .sig_next (sig_next)
  );

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign pass  = pass_q;
  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_c499_misr.sv
// Bench for c499_misr: four instances with different run lengths share one
// stimulus stream; each is checked every cycle against a behavioural model
// plus directed literal checks from the test plan.
module tb_c499_misr;
  import c499_bist_pkg::*;

  localparam logic [31:0] P = 32'h04C11DB7;
  localparam logic [31:0] S = 32'h00000000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        start      = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data  = '0;
  logic [31:0] expected   = '0;

  logic        busy_o [4];
  logic        done_o [4];
  logic        pass_o [4];
  logic [31:0] sig_o  [4];
  logic [15:0] cnt_o  [4];
  misr_state_t st_o   [4];

  c499_misr #(.NUM_PATTERNS(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp_data(resp_data), .expected(expected), .busy(busy_o[0]),
    .done(done_o[0]), .pass(pass_o[0]), .signature(sig_o[0]),
    .count(cnt_o[0]), .state(st_o[0]));
  c499_misr #(.NUM_PATTERNS(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp_data(resp_data), .expected(expected), .busy(busy_o[1]),
    .done(done_o[1]), .pass(pass_o[1]), .signature(sig_o[1]),
    .count(cnt_o[1]), .state(st_o[1]));
  c499_misr #(.NUM_PATTERNS(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp_data(resp_data), .expected(expected), .busy(busy_o[2]),
    .done(done_o[2]), .pass(pass_o[2]), .signature(sig_o[2]),
    .count(cnt_o[2]), .state(st_o[2]));
  c499_misr #(.NUM_PATTERNS(1024)) u_dk (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp_data(resp_data), .expected(expected), .busy(busy_o[3]),
    .done(done_o[3]), .pass(pass_o[3]), .signature(sig_o[3]),
    .count(cnt_o[3]), .state(st_o[3]));

  // reference model: phase 0 idle, 1 running, 2 finished
  int          n_pat  [4] = '{1, 2, 8, 1024};
  int          m_phase[4];
  logic [31:0] m_sig  [4];
  int          m_cnt  [4];
  logic        m_pass [4];

  int checks   = 0;
  int failures = 0;

  // Polynomial view of one fold: multiply by x, reduce modulo x^32+POLY,
  // add the response word.
  function automatic logic [31:0] ref_fold(input logic [31:0] s, input logic [31:0] d);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ {1'b1, P};
    return t[31:0] ^ d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_phase[i] = 0; m_sig[i] = S; m_cnt[i] = 0; m_pass[i] = 1'b0;
      end else if (m_phase[i] != 1 && start) begin
        m_phase[i] = 1; m_sig[i] = S; m_cnt[i] = 0; m_pass[i] = 1'b0;
      end else if (m_phase[i] == 1 && resp_valid) begin
        m_sig[i] = ref_fold(m_sig[i], resp_data);
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == n_pat[i]) begin
          m_phase[i] = 2;
          m_pass[i]  = (m_sig[i] == expected);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("m%0d_sig", i),   64'(sig_o[i]),  64'(m_sig[i]));
      chk($sformatf("m%0d_cnt", i),   64'(cnt_o[i]),  64'(m_cnt[i]));
      chk($sformatf("m%0d_busy", i),  64'(busy_o[i]), 64'(m_phase[i] == 1));
      chk($sformatf("m%0d_done", i),  64'(done_o[i]), 64'(m_phase[i] == 2));
      chk($sformatf("m%0d_state", i), 64'(st_o[i] == ST_DONE), 64'(m_phase[i] == 2));
      chk($sformatf("m%0d_pass", i),  64'(pass_o[i]), 64'(m_pass[i]));
    end
  endtask

  // one clock: model follows the edge, outputs are sampled 1 unit later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic st, input logic v, input logic [31:0] d);
    start = st; resp_valid = v; resp_data = d;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  int guard;

  initial begin
    // reset state
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_sig",  64'(sig_o[2]),  64'h0);
    chk("rst_busy", 64'(busy_o[2]), 64'h0);
    chk("rst_done", 64'(done_o[2]), 64'h0);

    // single sample on the NUM_PATTERNS=1 instance
    drive(1'b1, 1'b0, 32'h0);
    chk("single_busy", 64'(busy_o[0]), 64'h1);
    drive(1'b0, 1'b1, 32'h00000001);
    chk("single_sig",  64'(sig_o[0]),  64'h1);
    chk("single_done", 64'(done_o[0]), 64'h1);
    chk("single_cnt",  64'(cnt_o[0]),  64'h1);

    // feedback, matching golden value
    do_reset();
    expected = 32'h04C11DB7;
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h80000000);
    chk("fb_sig1", 64'(sig_o[1]), 64'h80000000);
    drive(1'b0, 1'b1, 32'h00000000);
    chk("fb_sig2",  64'(sig_o[1]),  64'h04C11DB7);
    chk("fb_pass1", 64'(pass_o[1]), 64'h1);
    chk("fb_done",  64'(done_o[1]), 64'h1);

    // feedback, mismatching golden value
    do_reset();
    expected = 32'h0;
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h80000000);
    drive(1'b0, 1'b1, 32'h00000000);
    chk("fb_pass0", 64'(pass_o[1]), 64'h0);
    chk("fb_done0", 64'(done_o[1]), 64'h1);

    // valid gaps, with start pulsed during RUN
    do_reset();
    expected = 32'h04C11DB7;
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h80000000);
    for (int g = 0; g < 5; g++) begin
      drive(g == 1, 1'b0, $urandom);
      chk("gap_busy", 64'(busy_o[1]), 64'h1);
      chk("gap_cnt",  64'(cnt_o[1]),  64'h1);
    end
    drive(1'b0, 1'b1, 32'h00000000);
    chk("gap_sig",  64'(sig_o[1]),  64'h04C11DB7);
    chk("gap_cnt2", 64'(cnt_o[1]),  64'h2);
    chk("gap_pass", 64'(pass_o[1]), 64'h1);

    // samples presented in DONE are ignored
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, $urandom);
      chk("done_sig_hold", 64'(sig_o[1]), 64'h04C11DB7);
      chk("done_cnt_hold", 64'(cnt_o[1]), 64'h2);
    end

    // start in DONE begins a fresh run and clears pass
    drive(1'b1, 1'b0, 32'h0);
    chk("restart_pass", 64'(pass_o[1]), 64'h0);
    chk("restart_busy", 64'(busy_o[1]), 64'h1);
    chk("restart_cnt",  64'(cnt_o[1]),  64'h0);
    chk("restart_sig",  64'(sig_o[1]),  64'(S));

    // reset in the middle of an 8-pattern run
    do_reset();
    drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, $urandom);
    chk("mid_cnt_pre", 64'(cnt_o[2]), 64'h3);
    rst = 1'b1;
    drive(1'b1, 1'b1, $urandom);
    rst = 1'b0;
    chk("mid_sig",  64'(sig_o[2]),  64'(S));
    chk("mid_cnt",  64'(cnt_o[2]),  64'h0);
    chk("mid_busy", 64'(busy_o[2]), 64'h0);
    chk("mid_done", 64'(done_o[2]), 64'h0);
    chk("mid_pass", 64'(pass_o[2]), 64'h0);

    // full 1024-pattern run with random data and random valid gaps
    expected = $urandom;
    drive(1'b1, 1'b0, 32'h0);
    guard = 0;
    while (m_phase[3] == 1 && guard < 4000) begin
      if ($urandom_range(0, 3) != 0) begin
        if (m_cnt[3] == 1023) begin
          chk("full_done_early", 64'(done_o[3]), 64'h0);
          drive(1'b0, 1'b1, $urandom);
          chk("full_done_next", 64'(done_o[3]), 64'h1);
          chk("full_cnt",       64'(cnt_o[3]),  64'd1024);
        end else begin
          drive(1'b0, 1'b1, $urandom);
        end
      end else begin
        drive(1'b0, 1'b0, $urandom);
      end
      guard++;
    end
    chk("full_finished", 64'(m_phase[3] == 2 && done_o[3]), 64'h1);
    drive(1'b0, 1'b1, $urandom);
    chk("full_hold_cnt", 64'(cnt_o[3]), 64'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
